branch_resolve_unit: RTL
========================

# branch_resolve_unit

Parametrised branch-resolution stage for the pipelined MIPS core. It evaluates branch conditions on WIDTH-bit operands for the six existing compare kinds plus four register-register relational kinds. The result is latched in a one-stage pipeline register with stall and flush control. It also keeps a PC-indexed table of 2-bit saturating counters, which supplies next-branch predictions to fetch and flags mispredictions to the hazard unit.

## Interface
Parameters:
- WIDTH, 32, operand width in bits
- PC_WIDTH, 32, program-counter width
- IDX_BITS, 6, predictor index width; table depth = 2**IDX_BITS

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  a branch is presented this cycle
- stall  in  1  hold output register and table
- flush  in  1  kill the in-flight branch
- cmp_type  in  4  condition selector (codes in Operation)
- a1  in  WIDTH  first operand (forwarded)
- a2  in  WIDTH  second operand (forwarded)
- pc  in  PC_WIDTH  PC of the branch being resolved
- in_pred  in  1  prediction fetch made for this branch
- lookup_pc  in  PC_WIDTH  fetch-stage PC to predict
- pred_taken  out  1  combinational prediction for lookup_pc
- out_valid  out  1  registered: a resolved branch is present
- taken  out  1  registered condition result
- mispredict  out  1  registered: taken != in_pred, valid legal branch only
- illegal  out  1  registered: cmp_type unrecognised while in_valid
- out_pc  out  PC_WIDTH  registered pc of the resolved branch

## Operation
- Codes:
  - BEQ 0000: a1==a2
  - BNE 0101: a1!=a2
  - BLEZ 0110: signed a1<=0
  - BGTZ 0111: signed a1>0
  - BLTZ 1000: signed a1<0
  - BGEZ 1001: signed a1>=0
  - BLT 1010: signed a1<a2
  - BGE 1011: signed a1>=a2
  - BLTU 1100: unsigned a1<a2
  - BGEU 1101: unsigned a1>=a2
- Zero-compare codes ignore a2. All comparisons are full WIDTH, two's complement for the signed codes.
- Unrecognised code with in_valid: taken=0, mispredict=0, illegal=1, no table update.
- Table index is pc[IDX_BITS+1:2]. Counter values: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T. pred_taken = counter[lookup index] MSB.
- Accepted branch (in_valid & ~stall & ~flush & legal code):
  - taken: counter saturating +1
  - not taken: counter saturating -1
  - 11 stays 11; 00 stays 00.

## Timing
- Reset (async assert, sync release):
  - out_valid, taken, mispredict, illegal = 0; out_pc = 0
  - every counter = 01, so pred_taken = 0
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Priority at each edge is flush > stall > load.
  - flush: out_valid, taken, mispredict, illegal clear; no table update, even if stall is also high.
  - stall (no flush): all output registers and the table hold.
  - otherwise: the output register loads the computed values, with out_valid = in_valid. taken, mispredict and illegal are forced to 0 when in_valid is 0.
- pred_taken is purely combinational from table state.
- A same-cycle lookup and update to the same index returns the pre-update value (read-before-write).
- Reset asserted mid-operation discards the pending result and restores all counters to 01 immediately.

## Structure
- Shared package branch_pkg holds the cmp_type code constants and the counter encodings (SNT/WNT/WT/ST); the decoder and hazard unit import the same package.
- One sub-module, bpred_table: counter array with read port (lookup_pc index), update port (index, taken, enable), and async reset.
- Condition logic and the output register live in the top module.

## Test plan
- Reset, then BEQ a1=5 a2=5 pc=0x3000 in_pred=0 -> next cycle out_valid=1, taken=1, mispredict=1, out_pc=0x3000; counter[0] becomes 10, so pred_taken for lookup_pc=0x3000 is 1.
- BLTU a1=0xFFFFFFFF a2=1 -> taken=0; BLT with the same operands -> taken=1; BGEZ a1=0x80000000 -> taken=0.
- Four taken branches at pc=0x3004, then one not-taken -> counter goes 01→10→11→11→11→10; pred_taken stays 1 throughout.
- Valid branch with stall=1 for 3 cycles -> outputs and counter unchanged. Then flush=1 together with stall=1 -> out_valid=0 next cycle and counter unchanged.
- cmp_type=1111 with in_valid=1 -> illegal=1, taken=0, mispredict=0, no counter change.
- Lookup and update at the same index in one cycle -> pred_taken shows the old value. Assert reset_n=0 mid-stream -> all outputs 0 immediately and pred_taken=0 for all indices.

Source files
------------

// File: rtl/branch_pkg.sv
// -----------------------------------------------------------------------------
// branch_pkg
// Shared definitions for branch resolution: the condition-selector codes, the
// 2-bit predictor counter encodings, and the saturating counter step used by
// the prediction table. The decoder and hazard unit import the same package.
// -----------------------------------------------------------------------------
package branch_pkg;

  // Condition selector codes; any other value is an illegal branch.
  typedef enum logic [3:0] {
    CMP_BEQ  = 4'b0000,
    CMP_BNE  = 4'b0101,
    CMP_BLEZ = 4'b0110,
    CMP_BGTZ = 4'b0111,
    CMP_BLTZ = 4'b1000,
    CMP_BGEZ = 4'b1001,
    CMP_BLT  = 4'b1010,
    CMP_BGE  = 4'b1011,
    CMP_BLTU = 4'b1100,
    CMP_BGEU = 4'b1101
  } cmp_e;

  // Predictor counter states; the MSB is the predicted direction.
  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  // Saturating step towards the resolved direction.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken) begin
      if (ctr != CTR_ST) nxt = ctr + 2'd1;
      else               nxt = ctr;
    end else begin
      if (ctr != CTR_SNT) nxt = ctr - 2'd1;
      else                nxt = ctr;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bpred_table.sv
// -----------------------------------------------------------------------------
// bpred_table
// Array of 2**IDX_BITS two-bit saturating counters.
//   clk, reset_n    : clock, async active-low reset (all counters -> weak-NT)
//   rd_idx_i        : lookup index
//   rd_taken_o      : combinational prediction (counter MSB) at rd_idx_i
//   upd_idx_i       : index of the resolved branch
//   upd_taken_i     : resolved direction
//   upd_en_i        : apply the update at the next rising edge
// The read port sees registered state only, so a same-cycle update to the
// looked-up entry is observed only after the edge (read-before-write).
// -----------------------------------------------------------------------------
module bpred_table
  import branch_pkg::*;
#(
  parameter int IDX_BITS = 6
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IDX_BITS-1:0] rd_idx_i,
  output logic                rd_taken_o,
  input  logic [IDX_BITS-1:0] upd_idx_i,
  input  logic                upd_taken_i,
  input  logic                upd_en_i
);

  localparam int DEPTH = 1 << IDX_BITS;

  logic [1:0] ctr_q [DEPTH];

  // Counter storage: reset to weak-NT, step the resolved entry when enabled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        ctr_q[i] <= CTR_WNT;
      end
    end else if (upd_en_i) begin
      ctr_q[upd_idx_i] <= ctr_next(ctr_q[upd_idx_i], upd_taken_i);
    end
  end

  assign rd_taken_o = ctr_q[rd_idx_i][1];

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Evaluates the branch condition, registers the result for one cycle under
// flush/stall control, and trains/reads the PC-indexed predictor table.
//   clk, reset_n   : clock, async active-low reset
//   in_valid       : a branch is presented
//   stall, flush   : hold / kill (flush wins over stall)
//   cmp_type       : condition selector (branch_pkg::cmp_e)
//   a1, a2         : forwarded operands
//   pc, in_pred    : branch PC and the prediction fetch used for it
//   lookup_pc      : fetch PC to predict; pred_taken is its prediction
//   out_valid, taken, mispredict, illegal, out_pc : registered result
// -----------------------------------------------------------------------------
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int PC_WIDTH = 32,
  parameter int IDX_BITS = 6
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  input  logic                stall,
  input  logic                flush,
  input  logic [3:0]          cmp_type,
  input  logic [WIDTH-1:0]    a1,
  input  logic [WIDTH-1:0]    a2,
  input  logic [PC_WIDTH-1:0] pc,
  input  logic                in_pred,
  input  logic [PC_WIDTH-1:0] lookup_pc,
  output logic                pred_taken,
  output logic                out_valid,
  output logic                taken,
  output logic                mispredict,
  output logic                illegal,
  output logic [PC_WIDTH-1:0] out_pc
);

  logic                cond_taken_s;
  logic                cond_legal_s;
  logic                a1_neg_s;
  logic                a1_zero_s;
  logic                accept_s;
  logic                valid_d, taken_d, mispredict_d, illegal_d;
  logic                valid_q, taken_q, mispredict_q, illegal_q;
  logic [PC_WIDTH-1:0] pc_d, pc_q;
  logic                unused_lookup_s;

  assign a1_neg_s  = a1[WIDTH-1];
  assign a1_zero_s = (a1 == {WIDTH{1'b0}});

  // Condition evaluation; unknown codes are flagged illegal and never taken.
  always_comb begin
    cond_taken_s = 1'b0;
    cond_legal_s = 1'b1;
    case (cmp_type)
      CMP_BEQ:  cond_taken_s = (a1 == a2);
      CMP_BNE:  cond_taken_s = (a1 != a2);
      CMP_BLEZ: cond_taken_s = a1_neg_s | a1_zero_s;
      CMP_BGTZ: cond_taken_s = ~a1_neg_s & ~a1_zero_s;
      CMP_BLTZ: cond_taken_s = a1_neg_s;
      CMP_BGEZ: cond_taken_s = ~a1_neg_s;
      CMP_BLT:  cond_taken_s = ($signed(a1) <  $signed(a2));
      CMP_BGE:  cond_taken_s = ($signed(a1) >= $signed(a2));
      CMP_BLTU: cond_taken_s = (a1 <  a2);
      CMP_BGEU: cond_taken_s = (a1 >= a2);
      default: begin
        cond_taken_s = 1'b0;
        cond_legal_s = 1'b0;
      end
    endcase
  end

  assign accept_s = in_valid & ~stall & ~flush & cond_legal_s;

  // Output register next state: flush clears, stall holds, otherwise load.
  always_comb begin
    valid_d      = valid_q;
    taken_d      = taken_q;
    mispredict_d = mispredict_q;
    illegal_d    = illegal_q;
    pc_d         = pc_q;
    if (flush) begin
      valid_d      = 1'b0;
      taken_d      = 1'b0;
      mispredict_d = 1'b0;
      illegal_d    = 1'b0;
    end else if (stall) begin
      valid_d      = valid_q;
    end else begin
      valid_d      = in_valid;
      taken_d      = in_valid & cond_legal_s & cond_taken_s;
      mispredict_d = in_valid & cond_legal_s & (cond_taken_s != in_pred);
      illegal_d    = in_valid & ~cond_legal_s;
      pc_d         = pc;
    end
  end

  // Result pipeline register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q      <= 1'b0;
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      illegal_q    <= 1'b0;
      pc_q         <= {PC_WIDTH{1'b0}};
    end else begin
      valid_q      <= valid_d;
      taken_q      <= taken_d;
      mispredict_q <= mispredict_d;
      illegal_q    <= illegal_d;
      pc_q         <= pc_d;
    end
  end

  assign out_valid  = valid_q;
  assign taken      = taken_q;
  assign mispredict = mispredict_q;
  assign illegal    = illegal_q;
  assign out_pc     = pc_q;

  // Instructions are word aligned, so the index skips the two byte-offset bits.
  bpred_table #(
    .IDX_BITS (IDX_BITS)
  ) u_table (
    .clk         (clk),
    .reset_n     (reset_n),
    .rd_idx_i    (lookup_pc[IDX_BITS+1:2]),
    .rd_taken_o  (pred_taken),
    .upd_idx_i   (pc[IDX_BITS+1:2]),
    .upd_taken_i (cond_taken_s),
    .upd_en_i    (accept_s)
  );

  assign unused_lookup_s = ^{lookup_pc[PC_WIDTH-1:IDX_BITS+2], lookup_pc[1:0]};

endmodule
